// File: rtl/apb_mm_ctrl_v2.sv
// APB4 slave and control sequencer for the matmul accelerator (second generation).
// Decodes the register map, drives external operand/scratchpad storage, launches
// the engine and drains MAX_DIM*MAX_DIM result elements into a scratchpad target.
module apb_mm_ctrl_v2 #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int SP_NTARGETS = 4,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int NEL        = MAX_DIM * MAX_DIM,
  localparam int IW         = $clog2(NEL),
  localparam int SW         = BUS_WIDTH / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [ADDR_WIDTH-1:0]    paddr_i,
  input  logic [BUS_WIDTH-1:0]     pwdata_i,
  input  logic [SW-1:0]            pstrb_i,
  output logic [BUS_WIDTH-1:0]     prdata_o,
  output logic                     pready_o,
  output logic                     pslverr_o,
  output logic [1:0]               op_we_o,
  output logic [1:0]               op_row_o,
  output logic [BUS_WIDTH-1:0]     op_wdata_o,
  output logic [SW-1:0]            op_wstrb_o,
  input  logic [2*BUS_WIDTH-1:0]   op_rdata_i,
  output logic                     sp_we_o,
  output logic [1:0]               sp_tgt_o,
  output logic [IW-1:0]            sp_idx_o,
  output logic [BUS_WIDTH-1:0]     sp_wdata_o,
  input  logic [BUS_WIDTH-1:0]     sp_rdata_i,
  output logic                     start_o,
  input  logic                     eop_i,
  input  logic [BUS_WIDTH*NEL-1:0] result_i,
  input  logic [NEL-1:0]           ov_i,
  output logic                     busy_o,
  output logic                     irq_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic [15:0]     ctrl_q, ctrl_d;
  logic [NEL-1:0]  flags_q, flags_d;
  logic            done_q, done_d;
  logic            irq_q;
  logic            sp_wait_q;

  logic [2:0]      rsel;
  logic            acc;
  logic            busy;
  logic            tgt_bad;
  logic            err;
  logic            ok_wr;
  logic            sp_rd;
  logic            sp_addr;
  logic            drain_last;
  logic            unused_bits;

  assign rsel       = paddr_i[4:2];
  assign acc        = psel_i & penable_i & ~rst_i;
  assign busy       = (state_q != IDLE);
  assign drain_last = (state_q == DRAIN) && (k_q == IW'(NEL - 1));
  assign unused_bits = ^{paddr_i, ctrl_q};

  // A 2-bit target field can never exceed four targets
  if (SP_NTARGETS >= 4) begin : g_all_tgt
    assign tgt_bad = 1'b0;
  end else begin : g_tgt_chk
    assign tgt_bad = (ctrl_q[5:4] >= 2'(SP_NTARGETS));
  end

  assign err = (pwrite_i && (rsel == 3'd3 || rsel == 3'd5))
            || (rsel[2:1] == 2'b11)
            || (busy && !(rsel == 3'd4 && !pwrite_i))
            || (rsel == 3'd5 && tgt_bad);

  assign ok_wr   = acc & pwrite_i & ~err;
  assign sp_rd   = acc & ~pwrite_i & (rsel == 3'd5) & ~err;
  // Scratchpad address is presented from the setup phase so data is ready by the second access cycle
  assign sp_addr = psel_i & ~pwrite_i & (rsel == 3'd5) & ~busy & ~tgt_bad & ~rst_i;

  assign pready_o  = acc & ~(sp_rd & ~sp_wait_q);
  assign pslverr_o = acc & err;
  assign start_o   = ok_wr & (rsel == 3'd0) & pstrb_i[0] & pwdata_i[0];
  assign busy_o    = busy;
  assign irq_o     = irq_q;

  assign op_we_o    = {ok_wr & (rsel == 3'd2), ok_wr & (rsel == 3'd1)};
  assign op_row_o   = (psel_i & ~rst_i) ? paddr_i[6:5] : 2'b00;
  assign op_wdata_o = (|op_we_o) ? pwdata_i : '0;
  assign op_wstrb_o = (|op_we_o) ? pstrb_i : '0;

  // Read data mux; zero unless the access completes without error
  always_comb begin
    prdata_o = '0;
    if (acc && !pwrite_i && !err && pready_o) begin
      unique case (rsel)
        3'd0:    prdata_o = BUS_WIDTH'(ctrl_q);
        3'd1:    prdata_o = op_rdata_i[BUS_WIDTH-1:0];
        3'd2:    prdata_o = op_rdata_i[2*BUS_WIDTH-1:BUS_WIDTH];
        3'd3:    prdata_o = BUS_WIDTH'(flags_q);
        3'd4:    prdata_o = BUS_WIDTH'({done_q, busy});
        3'd5:    prdata_o = sp_rdata_i;
        default: prdata_o = '0;
      endcase
    end
  end

  // Register next values: strobed CTRL writes, DONE W1C, completion updates (set wins)
  always_comb begin
    ctrl_d  = ctrl_q;
    done_d  = done_q;
    flags_d = flags_q;
    if (ok_wr && rsel == 3'd0) begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (pstrb_i[b]) ctrl_d[b*8 +: 8] = pwdata_i[b*8 +: 8];
      end
    end
    if (ok_wr && rsel == 3'd4 && pstrb_i[0] && pwdata_i[1]) done_d = 1'b0;
    if (drain_last) begin
      flags_d   = ov_i;
      done_d    = 1'b1;
      ctrl_d[0] = 1'b0;
    end
  end

  // Sequencer next state and scratchpad port drive
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sp_we_o    = 1'b0;
    sp_tgt_o   = 2'b00;
    sp_idx_o   = '0;
    sp_wdata_o = '0;
    unique case (state_q)
      IDLE: if (start_o) state_d = RUN;
      RUN: begin
        if (eop_i) begin
          state_d = DRAIN;
          k_d     = '0;
        end
      end
      DRAIN: begin
        sp_we_o    = 1'b1;
        sp_tgt_o   = ctrl_q[3:2];
        sp_idx_o   = k_q;
        sp_wdata_o = result_i[k_q*BUS_WIDTH +: BUS_WIDTH];
        k_d        = k_q + 1'b1;
        if (drain_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sp_addr) begin
      sp_tgt_o = ctrl_q[5:4];
      sp_idx_o = paddr_i[5 +: IW];
    end
  end

  // State and register storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      k_q       <= '0;
      ctrl_q    <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      sp_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ctrl_q    <= ctrl_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      irq_q     <= done_d & ctrl_d[8];
      sp_wait_q <= sp_rd & ~sp_wait_q;
    end
  end

endmodule
